// File: rtl/speed_level_decoder.sv
// rtl/speed_level_decoder.sv - classifies the period of an asynchronous game clock into a difficulty level
//
// Purpose: measures the period of game_clk in clk_in cycles and decodes which
// of four power-of-two periods (2^(BASE_LOG2+n), n = 0..3) it matches within
// +/-TOL cycles. TOL must stay below 2^(BASE_LOG2-1) so that the acceptance
// windows of neighbouring levels cannot overlap.
//
// Ports:
//   clk_in       system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   game_clk     divided game clock, asynchronous to clk_in
//   level        decoded level 0..3, holds through errors
//   level_valid  high while level reflects the last accepted period
//   level_chg    one-cycle pulse when an accepted level is new or follows invalid
//   period_err   one-cycle pulse on an unclassifiable period or a timeout

module speed_level_decoder #(
    parameter int BASE_LOG2 = 27,
    parameter int TOL       = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       game_clk,
    output logic [1:0] level,
    output logic       level_valid,
    output logic       level_chg,
    output logic       period_err
);

    // Five extra bits leave headroom above the level-3 period plus tolerance,
    // so the timeout compare is reached long before the counter saturates.
    localparam int CW = BASE_LOG2 + 5;

    localparam logic [CW-1:0] TOL_W   = CW'(TOL);
    localparam logic [CW-1:0] TIMEOUT = CW'((64'd1 << (BASE_LOG2 + 3)) + 64'(TOL) + 64'd1);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        LOCKED
    } state_t;

    state_t state;
    state_t state_n;

    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          edge_pulse;
    logic [CW-1:0] period_cnt;
    logic          timeout;
    logic [3:0]    match;
    logic          match_any;
    logic [1:0]    match_lvl;

    logic [1:0]    level_n;
    logic          valid_n;
    logic          chg_n;
    logic          err_n;

    function automatic logic [CW-1:0] nominal(input int n);
        return CW'(64'd1 << (BASE_LOG2 + n));
    endfunction

    // Two flops resolve metastability; the third only provides the delayed
    // copy for rising-edge detection.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= game_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

    // On an edge cycle the counter holds the distance to the previous edge;
    // loading 1 (not 0) makes that value equal the period in cycles.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (edge_pulse) begin
            period_cnt <= CW'(1);
        end else if (period_cnt != {CW{1'b1}}) begin
            period_cnt <= period_cnt + CW'(1);
        end
    end

    assign timeout = (period_cnt == TIMEOUT);

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            match[n] = (period_cnt >= (nominal(n) - TOL_W)) &&
                       (period_cnt <= (nominal(n) + TOL_W));
        end
    end

    // Windows are disjoint, so at most one bit of match is set and a plain
    // encoder suffices.
    always_comb begin
        match_any = |match;
        match_lvl = 2'd0;
        if (match[1]) match_lvl = 2'd1;
        if (match[2]) match_lvl = 2'd2;
        if (match[3]) match_lvl = 2'd3;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= WAIT_FIRST;
            level       <= 2'd0;
            level_valid <= 1'b0;
            level_chg   <= 1'b0;
            period_err  <= 1'b0;
        end else begin
            state       <= state_n;
            level       <= level_n;
            level_valid <= valid_n;
            level_chg   <= chg_n;
            period_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level;
        valid_n = level_valid;
        chg_n   = 1'b0;
        err_n   = 1'b0;

        case (state)
            WAIT_FIRST: begin
                // The first edge has no predecessor, so it only arms the count.
                if (edge_pulse) begin
                    state_n = MEASURE;
                end
            end

            MEASURE, LOCKED: begin
                // Edge is checked before timeout so a period that ends exactly
                // on the timeout count is still classified (and rejected).
                if (edge_pulse) begin
                    if (match_any) begin
                        level_n = match_lvl;
                        valid_n = 1'b1;
                        chg_n   = !level_valid || (match_lvl != level);
                        state_n = LOCKED;
                    end else begin
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                        state_n = MEASURE;
                    end
                end else if (timeout) begin
                    valid_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = WAIT_FIRST;
                end
            end

            default: begin
                state_n = WAIT_FIRST;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/speed_level_decoder.md
SPEED_LEVEL_DECODER -- requirements
Module: speed_level_decoder

Interface
REQ-001 Parameter BASE_LOG2, default 27, log2 of the level-0 game-clock period in clk_in cycles; level n period = 2^(BASE_LOG2+n), n = 0..3.
REQ-002 Parameter TOL, default 8, accepted period deviation in cycles (±TOL); legal only if TOL < 2^(BASE_LOG2-1).
REQ-003 clk_in  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 game_clk  input  1  divided game clock from the frequency divider; treated as asynchronous.
REQ-006 level  output  2  decoded difficulty level, 0..3.
REQ-007 level_valid  output  1  high while level reflects the last accepted period.
REQ-008 level_chg  output  1  one-cycle pulse when an accepted level differs from the previous level or follows invalid.
REQ-009 period_err  output  1  one-cycle pulse on an unclassifiable period or timeout.

Function
REQ-010 game_clk SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; edge = sync2 & ~sync3, one cycle wide.
REQ-011 Period counter SHALL be BASE_LOG2+5 bits: loaded with 1 on the cycle after an edge pulse, then +1 per cycle, saturating at all-ones.
REQ-012 Measured period SHALL be the counter value on the cycle an edge pulse is present (cycles between consecutive edge pulses).
REQ-013 Classification: period P matches level n iff |P - 2^(BASE_LOG2+n)| <= TOL; at most one n can match.
REQ-014 FSM states SHALL be WAIT_FIRST, MEASURE, LOCKED.
REQ-015 WAIT_FIRST: on edge -> MEASURE, counter loaded; no classification.
REQ-016 MEASURE/LOCKED, on edge with match n: level<=n, level_valid<=1, state->LOCKED; level_chg pulses if previously invalid or n != old level.
REQ-017 MEASURE/LOCKED, on edge with no match: period_err pulses, level_valid<=0, level holds, state->MEASURE, counter reloaded.
REQ-018 Timeout: counter reaching 2^(BASE_LOG2+3)+TOL+1 without edge SHALL pulse period_err, clear level_valid, hold level, go to WAIT_FIRST.
REQ-019 Outputs update on the clk_in edge following the edge pulse (latency 1 cycle after edge pulse, 4 cycles after game_clk rise at worst).
REQ-020 Simultaneous timeout and edge: edge handling (REQ-016/017) SHALL win.
REQ-021 Consecutive matching periods of same level SHALL keep level_valid high with no level_chg.
REQ-022 level_chg and period_err SHALL never assert in the same cycle.

Reset
REQ-023 While rst high: level=0, level_valid=0, level_chg=0, period_err=0, counter=0, state=WAIT_FIRST, synchronizer flops=0.
REQ-024 Reset SHALL take effect on the next clk_in edge regardless of state; a measurement in progress is discarded.
REQ-025 First game_clk rise after reset SHALL only start measurement; it SHALL NOT produce level_valid.
REQ-026 If game_clk is high when rst deasserts, the synchronizer sees a rising edge and REQ-025 applies.

Verification (BASE_LOG2=4, TOL=2: periods 16/32/64/128, timeout 131)
REQ-027 rst, then game_clk 16 high/16 low -> after second rise level=1, level_valid=1, level_chg one pulse, period_err=0.
REQ-028 Locked at 1, switch to period 128 -> first full 128-cycle period gives level=3, level_chg one pulse; valid stays 1.
REQ-029 Period 40 while locked -> period_err one pulse, level_valid=0, level holds 1; next period 32 -> level_valid=1, level_chg pulse.
REQ-030 Period 17 then 14 -> both accepted as level 0; period 19 -> period_err.
REQ-031 game_clk stuck low after lock -> 131 cycles after last edge counter, period_err pulse, level_valid=0, state WAIT_FIRST; next two rises relock.
REQ-032 rst asserted mid-MEASURE for 1 cycle -> all outputs 0 next cycle; first following rise gives no level_valid.
